// File: rtl/bus_slot_arbiter.sv
// Time-sliced shared-bus arbiter: one bus cycle of CYCLE_LEN clocks per grant,
// fixed-priority channel PRIO_CH, round-robin among the remaining channels.
module bus_slot_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CYCLE_LEN  = 4,
  parameter int unsigned PRIO_CH    = 0
) (
  input  logic                         clk_sys_i,
  input  logic                         reset_i,
  input  logic [NUM_CH-1:0]            req_valid_i,
  output logic [NUM_CH-1:0]            req_ready_o,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_CH-1:0]            req_rw_ni,
  output logic [NUM_CH-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]        rsp_data_o,
  output logic [NUM_CH-1:0]            grant_o,
  output logic [ADDR_WIDTH-1:0]        bus_addr_o,
  output logic                         bus_addr_oe,
  input  logic [DATA_WIDTH-1:0]        bus_data_i,
  output logic [DATA_WIDTH-1:0]        bus_data_o,
  output logic                         bus_data_oe,
  output logic                         bus_rw_no,
  output logic                         ram_we_o
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PH_W  = $clog2(CYCLE_LEN);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYCLE_LEN - 1);
  localparam logic [PH_W-1:0]  WE_FIRST = PH_W'(2);
  localparam logic [PH_W-1:0]  WE_LAST  = PH_W'(CYCLE_LEN - 2);
  localparam logic [IDX_W-1:0] PRIO_IDX = IDX_W'(PRIO_CH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_next;
  logic [PH_W-1:0]  phase, phase_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic [NUM_CH-1:0] win_onehot;
  logic             found;
  logic             accept;
  logic             last_phase;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_CH];
  logic [DATA_WIDTH-1:0] data_arr [NUM_CH];

  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      addr_arr[n] = req_addr_i[n*ADDR_WIDTH +: ADDR_WIDTH];
      data_arr[n] = req_data_i[n*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Winner search: priority channel first, else first valid after rr_ptr
  // (wrapping back to rr_ptr itself), never landing on the priority channel.
  always_comb begin
    win_idx    = PRIO_IDX;
    found      = 1'b0;
    cand       = '0;
    win_onehot = '0;
    if (req_valid_i[PRIO_CH]) begin
      found = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
        cand = IDX_W'((32'(rr_ptr) + i) % NUM_CH);
        if (!found && cand != PRIO_IDX && req_valid_i[cand]) begin
          win_idx = cand;
          found   = 1'b1;
        end
      end
    end
    win_onehot[win_idx] = found;
  end

  always_comb begin
    last_phase  = (phase == PH_LAST);
    phase_next  = last_phase ? '0 : phase + 1'b1;
    accept      = (phase == '0) && found;
    req_ready_o = (phase == '0) ? win_onehot : '0;
    state_next  = state;
    if (phase == '0)
      state_next = found ? ACTIVE : IDLE;
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      rr_ptr      <= PRIO_IDX;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      grant_o     <= '0;
      bus_addr_o  <= '0;
      bus_addr_oe <= 1'b0;
      bus_data_o  <= '0;
      bus_data_oe <= 1'b0;
      bus_rw_no   <= 1'b1;
      ram_we_o    <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      if (accept) begin
        grant_o     <= win_onehot;
        bus_addr_oe <= 1'b1;
        bus_addr_o  <= addr_arr[win_idx];
        bus_rw_no   <= req_rw_ni[win_idx];
        bus_data_oe <= !req_rw_ni[win_idx];
        bus_data_o  <= data_arr[win_idx];
        if (win_idx != PRIO_IDX)
          rr_ptr <= win_idx;
      end else if (last_phase) begin
        if (state == ACTIVE) begin
          rsp_valid_o <= grant_o;
          if (bus_rw_no)
            rsp_data_o <= bus_data_i;
        end
        grant_o     <= '0;
        bus_addr_oe <= 1'b0;
        bus_data_oe <= 1'b0;
        bus_rw_no   <= 1'b1;
      end
      ram_we_o <= (state == ACTIVE) && !bus_rw_no && !accept
                  && (phase_next >= WE_FIRST) && (phase_next <= WE_LAST);
    end
  end

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Directed self-checking bench for bus_slot_arbiter (NUM_CH=4, CYCLE_LEN=4).
module tb_bus_slot_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 17;
  localparam int unsigned DW  = 8;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic [NCH-1:0]    req_valid_i = '0;
  logic [NCH-1:0]    req_ready_o;
  logic [NCH*AW-1:0] req_addr_i = '0;
  logic [NCH*DW-1:0] req_data_i = '0;
  logic [NCH-1:0]    req_rw_ni = '1;
  logic [NCH-1:0]    rsp_valid_o;
  logic [DW-1:0]     rsp_data_o;
  logic [NCH-1:0]    grant_o;
  logic [AW-1:0]     bus_addr_o;
  logic              bus_addr_oe;
  logic [DW-1:0]     bus_data_i = '0;
  logic [DW-1:0]     bus_data_o;
  logic              bus_data_oe;
  logic              bus_rw_no;
  logic              ram_we_o;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  bus_slot_arbiter #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CYCLE_LEN(4), .PRIO_CH(0)
  ) dut (
    .clk_sys_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_rw_ni(req_rw_ni),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .grant_o(grant_o),
    .bus_addr_o(bus_addr_o), .bus_addr_oe(bus_addr_oe),
    .bus_data_i(bus_data_i), .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe),
    .bus_rw_no(bus_rw_no), .ram_we_o(ram_we_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns into the phase-0 clock right after release.
  task automatic do_reset();
    req_valid_i = '0;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL rst_grant got %b exp %b", grant_o, 4'b0000); end
    n_cmp++; if (bus_addr_oe !== 1'b0) begin n_fail++; $display("FAIL rst_addr_oe got %b exp 0", bus_addr_oe); end
    n_cmp++; if (bus_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_data_oe got %b exp 0", bus_data_oe); end
    n_cmp++; if (ram_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", ram_we_o); end
    n_cmp++; if (bus_rw_no !== 1'b1) begin n_fail++; $display("FAIL rst_rw got %b exp 1", bus_rw_no); end
    n_cmp++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL rst_rsp_valid got %b exp %b", rsp_valid_o, 4'b0000); end
    n_cmp++; if (rsp_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data got %h exp %h", rsp_data_o, 8'h00); end
    n_cmp++; if (bus_addr_o !== 17'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", bus_addr_o); end
  endtask

  task automatic test_reset_midcycle();
    do_reset();
    req_valid_i[1] = 1'b1; req_rw_ni[1] = 1'b0;
    req_addr_i[1*AW +: AW] = 17'h01234; req_data_i[1*DW +: DW] = 8'h5A;
    tick();                               // accepted, phase 1
    req_valid_i = '0;
    tick();                               // phase 2
    n_cmp++; if (ram_we_o !== 1'b1) begin n_fail++; $display("FAIL mrst_we_before got %b exp 1", ram_we_o); end
    reset_i = 1'b1;
    tick();
    n_cmp++; if (ram_we_o !== 1'b0) begin n_fail++; $display("FAIL mrst_we_drop got %b exp 0", ram_we_o); end
    n_cmp++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL mrst_grant got %b exp 0000", grant_o); end
    tick();
    reset_i = 1'b0;                       // phase 0 now
    n_cmp++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL mrst_rsp0 got %b exp 0000", rsp_valid_o); end
    req_valid_i[2] = 1'b1;
    #1;
    n_cmp++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL mrst_ready_ph0 got %b exp 0100", req_ready_o); end
    req_valid_i = '0;                     // withdrawn before the edge: never issued
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (rsp_valid_o !== 4'b0000 || bus_addr_oe !== 1'b0) begin
        n_fail++; $display("FAIL mrst_quiet[%0d] rsp %b addr_oe %b exp 0000/0", k, rsp_valid_o, bus_addr_oe);
      end
    end
  endtask

  task automatic test_write();
    logic [3:0] exp_oe;
    logic [3:0] exp_we;
    do_reset();
    exp_oe = 4'b1110;                     // indexed by phase
    exp_we = 4'b0100;
    req_valid_i[1] = 1'b1; req_rw_ni[1] = 1'b0;
    req_addr_i[1*AW +: AW] = 17'h08000; req_data_i[1*DW +: DW] = 8'hA5;
    #1;
    n_cmp++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL wr_ready got %b exp 0010", req_ready_o); end
    tick();
    req_valid_i = '0;
    n_cmp++; if (grant_o !== 4'b0010) begin n_fail++; $display("FAIL wr_grant got %b exp 0010", grant_o); end
    n_cmp++; if (bus_addr_o !== 17'h08000 || bus_addr_oe !== 1'b1) begin n_fail++; $display("FAIL wr_addr got %h/%b exp 08000/1", bus_addr_o, bus_addr_oe); end
    n_cmp++; if (bus_data_o !== 8'hA5 || bus_rw_no !== 1'b0) begin n_fail++; $display("FAIL wr_data got %h/%b exp a5/0", bus_data_o, bus_rw_no); end
    for (int p = 1; p < 4; p++) begin
      n_cmp++; if (bus_data_oe !== exp_oe[p] || ram_we_o !== exp_we[p]) begin
        n_fail++; $display("FAIL wr_ph%0d oe/we got %b/%b exp %b/%b", p, bus_data_oe, ram_we_o, exp_oe[p], exp_we[p]);
      end
      n_cmp++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL wr_ready_ph%0d got %b exp 0000", p, req_ready_o); end
      tick();
    end
    n_cmp++; if (rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL wr_rsp got %b exp 0010", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== 8'h00) begin n_fail++; $display("FAIL wr_rsp_data got %h exp 00", rsp_data_o); end
    n_cmp++; if (bus_data_oe !== 1'b0 || grant_o !== 4'b0000 || ram_we_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_end oe/grant/we got %b/%b/%b exp 0/0000/0", bus_data_oe, grant_o, ram_we_o);
    end
    tick();
    n_cmp++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL wr_rsp_pulse got %b exp 0000", rsp_valid_o); end
  endtask

  task automatic test_read();
    do_reset();
    req_valid_i[2] = 1'b1; req_rw_ni[2] = 1'b1; req_addr_i[2*AW +: AW] = 17'h0E80F;
    tick();
    req_valid_i = '0;
    n_cmp++; if (grant_o !== 4'b0100 || bus_addr_o !== 17'h0E80F) begin n_fail++; $display("FAIL rd_grant_addr got %b/%h exp 0100/0e80f", grant_o, bus_addr_o); end
    n_cmp++; if (bus_data_oe !== 1'b0 || bus_rw_no !== 1'b1) begin n_fail++; $display("FAIL rd_dir got oe %b rw %b exp 0/1", bus_data_oe, bus_rw_no); end
    tick();
    n_cmp++; if (ram_we_o !== 1'b0) begin n_fail++; $display("FAIL rd_we got %b exp 0", ram_we_o); end
    tick();
    bus_data_i = 8'h3C;                   // phase 3
    tick();
    bus_data_i = 8'hFF;
    n_cmp++; if (rsp_valid_o !== 4'b0100) begin n_fail++; $display("FAIL rd_rsp got %b exp 0100", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== 8'h3C) begin n_fail++; $display("FAIL rd_rsp_data got %h exp 3c", rsp_data_o); end
    // A following write must leave rsp_data_o at the last read value.
    req_valid_i[3] = 1'b1; req_rw_ni[3] = 1'b0; req_data_i[3*DW +: DW] = 8'h77;
    tick();
    req_valid_i = '0;
    tick(); tick(); tick();
    n_cmp++; if (rsp_valid_o !== 4'b1000 || rsp_data_o !== 8'h3C) begin
      n_fail++; $display("FAIL rd_hold got %b/%h exp 1000/3c", rsp_valid_o, rsp_data_o);
    end
    bus_data_i = 8'h00;
  endtask

  task automatic test_priority();
    logic [3:0] rr_seq [4];
    rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    do_reset();
    req_rw_ni = '1;
    req_valid_i = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL pri_ready[%0d] got %b exp 0001", c, req_ready_o); end
      tick();
      n_cmp++; if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL pri_grant[%0d] got %b exp 0001", c, grant_o); end
      tick(); tick(); tick();
    end
    req_valid_i = 4'b1110;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (req_ready_o !== rr_seq[c]) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", c, req_ready_o, rr_seq[c]); end
      tick();
      n_cmp++; if (grant_o !== rr_seq[c]) begin n_fail++; $display("FAIL rr_grant[%0d] got %b exp %b", c, grant_o, rr_seq[c]); end
      tick(); tick(); tick();
    end
    req_valid_i = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [5];
    seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
    do_reset();
    req_rw_ni = 4'b0101;                  // ch1 and ch3 write
    req_valid_i = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (req_ready_o !== seq[c]) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b exp %b", c, req_ready_o, seq[c]); end
      if (c > 0) begin
        n_cmp++; if (rsp_valid_o !== seq[c-1]) begin n_fail++; $display("FAIL b2b_rsp[%0d] got %b exp %b", c, rsp_valid_o, seq[c-1]); end
      end
      for (int p = 1; p < 4; p++) begin
        tick();
        n_cmp++; if (bus_addr_oe !== 1'b1 || grant_o !== seq[c]) begin
          n_fail++; $display("FAIL b2b_busy[%0d.%0d] oe %b grant %b exp 1/%b", c, p, bus_addr_oe, grant_o, seq[c]);
        end
      end
      if (c == 4) req_valid_i = '0;
      tick();
    end
    n_cmp++; if (rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL b2b_last_rsp got %b exp 0010", rsp_valid_o); end
    req_rw_ni = '1;
  endtask

  task automatic test_idle();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++; if (bus_addr_oe !== 1'b0 || bus_data_oe !== 1'b0 || ram_we_o !== 1'b0 || grant_o !== 4'b0000) begin
        n_fail++; $display("FAIL idle[%0d] aoe %b doe %b we %b grant %b exp 0/0/0/0000", k, bus_addr_oe, bus_data_oe, ram_we_o, grant_o);
      end
    end
    // 12 clocks after phase 0 the counter sits at phase 0 again.
    tick();                               // phase 1
    req_valid_i[3] = 1'b1;
    #1;
    n_cmp++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL idle_ready_ph1 got %b exp 0000", req_ready_o); end
    tick(); tick();                       // phase 3
    n_cmp++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL idle_ready_ph3 got %b exp 0000", req_ready_o); end
    tick();                               // phase 0
    n_cmp++; if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL idle_ready_ph0 got %b exp 1000", req_ready_o); end
    req_valid_i = '0;
  endtask

  initial begin
    test_reset();
    test_reset_midcycle();
    test_write();
    test_read();
    test_priority();
    test_back_to_back();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
